// File: rtl/pwm_clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// pwm_clk_gen_pkg
// Shared types and constants for the PWM clock generator slice.
//   _pwm_onoff    : PWM run state; only PWM_OFF allows divider shadow loads
//   _clkgen_state : per-channel divider FSM state
//   PWM_N_CLK     : number of generated PWM clocks
//   PWM_CLK_DIV_W : divider field width (half-period = div + 1 clk cycles)
// ---------------------------------------------------------------------------
package pwm_clk_gen_pkg;

  typedef enum logic [1:0] {
    PWM_OFF   = 2'd0,
    PWM_ON    = 2'd1,
    PWM_PAUSE = 2'd2
  } _pwm_onoff;

  typedef enum logic [1:0] {
    CLKGEN_IDLE = 2'd0,
    CLKGEN_LOW  = 2'd1,
    CLKGEN_HIGH = 2'd2
  } _clkgen_state;

  localparam int PWM_N_CLK     = 4;
  localparam int PWM_CLK_DIV_W = 16;

endpackage

// File: rtl/pwm_clk_div.sv
// ---------------------------------------------------------------------------
// pwm_clk_div
// One divided-clock channel: IDLE/LOW/HIGH state machine with a half-period
// counter. Output and tick are registered.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-low reset
//   en       in  channel enable; low forces IDLE on the next edge
//   div_sh   in  frozen half-period minus one
//   restart  in  restart the channel in LOW with a cleared counter
//   clk_out  out divided clock, 50% duty
//   tick     out one-cycle pulse in the first cycle clk_out is high
// ---------------------------------------------------------------------------
module pwm_clk_div
  import pwm_clk_gen_pkg::*;
#(
  parameter int DIV_W = PWM_CLK_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_sh,
  input  logic             restart,
  output logic             clk_out,
  output logic             tick
);

  _clkgen_state     state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             out_nxt;
  logic             tick_nxt;

  // State, counter, output and tick all live in flops so nothing
  // combinational reaches the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLKGEN_IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      clk_out <= out_nxt;
      tick    <= tick_nxt;
    end
  end

  // Disable beats restart, restart beats the normal phase progression.
  // The counter is compared against div_sh exactly, so it can never run
  // past the divider; a divider change always comes with a restart.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = clk_out;
    tick_nxt  = 1'b0;
    if (!en) begin
      state_nxt = CLKGEN_IDLE;
      cnt_nxt   = '0;
      out_nxt   = 1'b0;
    end else if (restart) begin
      state_nxt = CLKGEN_LOW;
      cnt_nxt   = '0;
      out_nxt   = 1'b0;
    end else begin
      case (state)
        CLKGEN_IDLE: begin
          state_nxt = CLKGEN_LOW;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
        end
        CLKGEN_LOW: begin
          if (cnt == div_sh) begin
            state_nxt = CLKGEN_HIGH;
            cnt_nxt   = '0;
            out_nxt   = 1'b1;
            tick_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
            out_nxt = 1'b0;
          end
        end
        CLKGEN_HIGH: begin
          if (cnt == div_sh) begin
            state_nxt = CLKGEN_LOW;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
            out_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = CLKGEN_IDLE;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_clk_gen.sv
// ---------------------------------------------------------------------------
// pwm_clk_gen
// Generates four PWM clocks from clk with independent dividers. Divider
// requests are copied into shadows only while PWM is off, so a running
// carrier never sees its clock change rate.
// Ports:
//   clk                 in  system clock
//   reset               in  asynchronous, active-low reset
//   pwm_onoff           in  PWM run state; shadows load only at PWM_OFF
//   ch_en[3:0]          in  per-channel enable
//   div0..div3          in  requested half-period minus one
//   pwm0_clk..pwm3_clk  out divided clocks, 50% duty, registered
//   pwm_tick[3:0]       out one-cycle pulse when the matching clock rises
// Build option:
//   PWM_CLK_GEN_PHASE_ALIGN_EN - when defined, the edge from PWM_OFF into a
//   running state restarts every channel together so their phases line up.
// ---------------------------------------------------------------------------
module pwm_clk_gen
  import pwm_clk_gen_pkg::*;
#(
  parameter int DIV_W = PWM_CLK_DIV_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  _pwm_onoff            pwm_onoff,
  input  logic [PWM_N_CLK-1:0] ch_en,
  input  logic [DIV_W-1:0]     div0,
  input  logic [DIV_W-1:0]     div1,
  input  logic [DIV_W-1:0]     div2,
  input  logic [DIV_W-1:0]     div3,
  output logic                 pwm0_clk,
  output logic                 pwm1_clk,
  output logic                 pwm2_clk,
  output logic                 pwm3_clk,
  output logic [PWM_N_CLK-1:0] pwm_tick
);

  logic [DIV_W-1:0]     div_req [PWM_N_CLK];
  logic [DIV_W-1:0]     div_sh  [PWM_N_CLK];
  logic                 shadow_load;
  logic                 align_restart;
  logic [PWM_N_CLK-1:0] restart;
  logic [PWM_N_CLK-1:0] clk_vec;

  assign div_req[0] = div0;
  assign div_req[1] = div1;
  assign div_req[2] = div2;
  assign div_req[3] = div3;

  assign shadow_load = (pwm_onoff == PWM_OFF);

  // Shadow copies follow the requests every cycle PWM is off and hold
  // otherwise; the run state seen at the edge decides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PWM_N_CLK; i++) begin
        div_sh[i] <= '0;
      end
    end else if (shadow_load) begin
      for (int i = 0; i < PWM_N_CLK; i++) begin
        div_sh[i] <= div_req[i];
      end
    end
  end

`ifdef PWM_CLK_GEN_PHASE_ALIGN_EN
  logic prev_off;

  // Remember whether PWM was off last cycle so the first running cycle
  // can restart every channel at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_off <= 1'b1;
    end else begin
      prev_off <= shadow_load;
    end
  end

  assign align_restart = prev_off && !shadow_load;
`else
  assign align_restart = 1'b0;
`endif

  // A channel restarts in the same edge its shadow takes a different
  // value, so the new rate starts from a clean LOW phase.
  always_comb begin
    restart = '0;
    for (int i = 0; i < PWM_N_CLK; i++) begin
      restart[i] = align_restart || (shadow_load && (div_req[i] != div_sh[i]));
    end
  end

  for (genvar g = 0; g < PWM_N_CLK; g++) begin : g_ch
    pwm_clk_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk    (clk),
      .reset  (reset),
      .en     (ch_en[g]),
      .div_sh (div_sh[g]),
      .restart(restart[g]),
      .clk_out(clk_vec[g]),
      .tick   (pwm_tick[g])
    );
  end

  assign pwm0_clk = clk_vec[0];
  assign pwm1_clk = clk_vec[1];
  assign pwm2_clk = clk_vec[2];
  assign pwm3_clk = clk_vec[3];

endmodule
